// File: rtl/wtc_7seg_pkg.sv
// Shared definitions for the 7-segment sequencer and the driver it feeds:
// sequencer state encoding, display mode codes and the blank encoding.
package wtc_7seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_e;

    // Mode codes understood by the 7-segment driver
    localparam logic [2:0] MODE_NORMAL = 3'd0;
    localparam logic [2:0] MODE_BLINK  = 3'd1;
    localparam logic [2:0] MODE_DOT    = 3'd2;

    // Blank encoding on the driver's blank input
    localparam logic BLANK_ON  = 1'b1;
    localparam logic BLANK_OFF = 1'b0;

    // Width of requester indices (up to four requesters)
    localparam int OWNER_W = 2;

endpackage

// File: rtl/wtc_rr_arbiter.sv
// Combinational round-robin pick: starting at ptr, the first set request
// bit wins. Produces a one-hot grant, its index and a valid flag.
module wtc_rr_arbiter
    import wtc_7seg_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [OWNER_W-1:0] grant_idx,
    output logic               grant_valid
);

    logic [3:0] req_ext;
    logic [2:0] cand;

    // Requests padded to four so candidate indices never go out of range
    always_comb begin
        req_ext = 4'(req);
    end

    // Scan pointer, pointer+1, ... (mod NUM_REQ) and keep the first hit
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + 3'(i);
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            if (!grant_valid && req_ext[cand[1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[1:0];
            end
        end
    end

    // One-hot grant derived from the winning index
    always_comb begin
        grant = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant[j] = grant_valid && (grant_idx == OWNER_W'(j));
        end
    end

endmodule

// File: rtl/wtc_7seg_sequencer.sv
// Shares one 7-segment digit between several requesters. Each accepted
// request is latched and shown for HOLD_CYCLES clocks, followed by
// GAP_CYCLES blank clocks, with round-robin arbitration between requesters.
module wtc_7seg_sequencer
    import wtc_7seg_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int HOLD_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 2500000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [4*NUM_REQ-1:0]   i_value,
    input  logic [3*NUM_REQ-1:0]   i_mode,
    input  logic                   i_flush,
    output logic [NUM_REQ-1:0]     o_ack,
    output logic [3:0]             o_binary_num,
    output logic [2:0]             o_mode,
    output logic                   o_blank,
    output logic [OWNER_W-1:0]     o_owner,
    output logic                   o_busy
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Terminal values are compared for equality, so the counter never wraps
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OWNER_W-1:0] ptr_q, ptr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [3:0]         num_q, num_d;
    logic [2:0]         mode_q, mode_d;
    logic               blank_q, blank_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] grant;
    logic [OWNER_W-1:0] grant_idx;
    logic               grant_valid;
    logic [3:0]         sel_value;
    logic [2:0]         sel_mode;
    logic [OWNER_W-1:0] ptr_after_grant;

    wtc_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .req         (i_req),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Select the winning requester's digit and mode slices
    always_comb begin
        sel_value = '0;
        sel_mode  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == OWNER_W'(k)) begin
                sel_value = i_value[4*k +: 4];
                sel_mode  = i_mode[3*k +: 3];
            end
        end
    end

    // Pointer moves just past the winner so it competes last next time
    always_comb begin
        if (grant_idx == OWNER_W'(NUM_REQ - 1)) begin
            ptr_after_grant = '0;
        end else begin
            ptr_after_grant = grant_idx + OWNER_W'(1);
        end
    end

    // Next-state and next-output logic; flush overrides every state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        num_d   = num_q;
        mode_d  = mode_q;
        blank_d = blank_q;
        owner_d = owner_q;
        busy_d  = busy_q;

        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            blank_d = BLANK_ON;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    blank_d = BLANK_ON;
                    busy_d  = 1'b0;
                    if (grant_valid) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                        ack_d   = grant;
                        num_d   = sel_value;
                        mode_d  = sel_mode;
                        owner_d = grant_idx;
                        blank_d = BLANK_OFF;
                        busy_d  = 1'b1;
                        ptr_d   = ptr_after_grant;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        blank_d = BLANK_ON;
                        if (GAP_CYCLES > 0) begin
                            state_d = ST_GAP;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        blank_d = BLANK_ON;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    blank_d = BLANK_ON;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, counter, pointer and output registers with async reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
            num_q   <= '0;
            mode_q  <= MODE_NORMAL;
            blank_q <= BLANK_ON;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            num_q   <= num_d;
            mode_q  <= mode_d;
            blank_q <= blank_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign o_ack        = ack_q;
    assign o_binary_num = num_q;
    assign o_mode       = mode_q;
    assign o_blank      = blank_q;
    assign o_owner      = owner_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_wtc_7seg_sequencer.sv
// Self-checking bench for wtc_7seg_sequencer (NUM_REQ=2, HOLD=4, GAP=2)
// plus a second instance built with no gap state.
module tb_wtc_7seg_sequencer;
    import wtc_7seg_pkg::*;

    localparam int NREQ = 2;
    localparam int HOLD = 4;
    localparam int GAP  = 2;

    logic i_clk = 1'b0;
    logic i_rst_n;
    logic [NREQ-1:0]   i_req;
    logic [4*NREQ-1:0] i_value;
    logic [3*NREQ-1:0] i_mode;
    logic              i_flush;
    logic [NREQ-1:0]   o_ack;
    logic [3:0]        o_binary_num;
    logic [2:0]        o_mode;
    logic              o_blank;
    logic [1:0]        o_owner;
    logic              o_busy;

    logic [NREQ-1:0]   ng_req;
    logic [4*NREQ-1:0] ng_value;
    logic [3*NREQ-1:0] ng_mode;
    logic              ng_flush;
    logic [NREQ-1:0]   ng_ack;
    logic [3:0]        ng_num;
    logic [2:0]        ng_mode_o;
    logic              ng_blank;
    logic [1:0]        ng_owner;
    logic              ng_busy;

    typedef struct {
        logic [1:0] req;
        logic [7:0] value;
        logic [5:0] mode;
        logic [1:0] exp_owner;
        logic [3:0] exp_num;
        logic [2:0] exp_mode;
    } vec_t;

    typedef struct {
        logic [1:0] owner;
        logic [3:0] num;
        logic [2:0] mode;
    } sb_t;

    sb_t  sb_q[$];
    sb_t  sb_head;
    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    wtc_7seg_sequencer #(
        .NUM_REQ     (NREQ),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_value      (i_value),
        .i_mode       (i_mode),
        .i_flush      (i_flush),
        .o_ack        (o_ack),
        .o_binary_num (o_binary_num),
        .o_mode       (o_mode),
        .o_blank      (o_blank),
        .o_owner      (o_owner),
        .o_busy       (o_busy)
    );

    wtc_7seg_sequencer #(
        .NUM_REQ     (NREQ),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (0)
    ) dut_ng (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (ng_req),
        .i_value      (ng_value),
        .i_mode       (ng_mode),
        .i_flush      (ng_flush),
        .o_ack        (ng_ack),
        .o_binary_num (ng_num),
        .o_mode       (ng_mode_o),
        .o_blank      (ng_blank),
        .o_owner      (ng_owner),
        .o_busy       (ng_busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        i_req   = v.req;
        i_value = v.value;
        i_mode  = v.mode;
        sb_q.push_back('{v.exp_owner, v.exp_num, v.exp_mode});
    endtask

    // Scoreboard: every ack pulse must match the oldest pending expectation
    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1 && o_ack !== '0) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_ack", 32'(o_ack), 32'h0);
            end else begin
                sb_head = sb_q.pop_front();
                checkOutput("sb_ack", 32'(o_ack), 32'(2'b01 << sb_head.owner));
                checkOutput("sb_owner", 32'(o_owner), 32'(sb_head.owner));
                checkOutput("sb_num", 32'(o_binary_num), 32'(sb_head.num));
                checkOutput("sb_mode", 32'(o_mode), 32'(sb_head.mode));
                checkOutput("sb_blank", 32'(o_blank), 32'(BLANK_OFF));
            end
        end
    end

    task automatic waitIdle(input string name);
        int k;
        k = 0;
        do begin
            @(negedge i_clk);
            k++;
        end while (o_busy !== 1'b0 && k < 30);
        checkOutput(name, 32'(o_busy), 32'h0);
    endtask

    // One full transaction: grant, hold with changed inputs, gap, idle
    task automatic runVector(input vec_t v);
        int show_ok;
        int gap_ok;
        show_ok = 0;
        gap_ok  = 0;
        applyStimulus(v);
        @(negedge i_clk);
        checkOutput("vec_busy", 32'(o_busy), 32'h1);
        i_req   = '0;
        i_value = ~v.value;
        i_mode  = ~v.mode;
        for (int k = 1; k < HOLD; k++) begin
            @(negedge i_clk);
            if (o_blank === 1'b0 && o_busy === 1'b1 && o_ack === '0 &&
                o_binary_num === v.exp_num && o_mode === v.exp_mode)
                show_ok++;
        end
        checkOutput("vec_show_cycles", 32'(show_ok), 32'(HOLD - 1));
        for (int k = 0; k < GAP; k++) begin
            @(negedge i_clk);
            if (o_blank === 1'b1 && o_busy === 1'b1 && o_ack === '0 &&
                o_binary_num === v.exp_num && o_mode === v.exp_mode)
                gap_ok++;
        end
        checkOutput("vec_gap_cycles", 32'(gap_ok), 32'(GAP));
        @(negedge i_clk);
        checkOutput("vec_idle_busy", 32'(o_busy), 32'h0);
        checkOutput("vec_idle_blank", 32'(o_blank), 32'h1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ack_cyc[4];
        int nacks;
        int ng_show;
        int t0;
        int k;

        vecs[0] = '{2'b01, 8'h5A, {3'd2, 3'd1}, 2'd0, 4'hA, 3'd1};
        vecs[1] = '{2'b11, 8'hC3, {3'd4, 3'd0}, 2'd1, 4'hC, 3'd4};
        vecs[2] = '{2'b11, 8'h7E, {3'd6, 3'd5}, 2'd0, 4'hE, 3'd5};
        vecs[3] = '{2'b01, 8'h1F, {3'd3, 3'd7}, 2'd0, 4'hF, 3'd7};
        vecs[4] = '{2'b10, 8'h90, {3'd2, 3'd2}, 2'd1, 4'h9, 3'd2};
        vecs[5] = '{2'b10, 8'hBD, {3'd1, 3'd3}, 2'd1, 4'hB, 3'd1};
        vecs[6] = '{2'b11, 8'h86, {3'd0, 3'd4}, 2'd0, 4'h6, 3'd4};
        vecs[7] = '{2'b10, 8'h42, {3'd5, 3'd6}, 2'd1, 4'h4, 3'd5};

        i_rst_n  = 1'b0;
        i_req    = '0;
        i_value  = '0;
        i_mode   = '0;
        i_flush  = 1'b0;
        ng_req   = '0;
        ng_value = '0;
        ng_mode  = '0;
        ng_flush = 1'b0;
        nacks    = 0;
        for (int i = 0; i < 4; i++) ack_cyc[i] = 0;

        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        checkOutput("rst_blank", 32'(o_blank), 32'(BLANK_ON));
        checkOutput("rst_busy", 32'(o_busy), 32'h0);
        checkOutput("rst_ack", 32'(o_ack), 32'h0);
        checkOutput("rst_num", 32'(o_binary_num), 32'h0);
        checkOutput("rst_mode", 32'(o_mode), 32'(MODE_NORMAL));
        checkOutput("rst_owner", 32'(o_owner), 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            checkOutput("idle_blank", 32'(o_blank), 32'h1);
            checkOutput("idle_busy", 32'(o_busy), 32'h0);
            checkOutput("idle_ack", 32'(o_ack), 32'h0);
        end

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) runVector(vecs[i]);

        $display("[TB] continuous requests");
        i_req   = 2'b11;
        i_value = 8'h5A;
        i_mode  = {MODE_DOT, MODE_BLINK};
        sb_q.push_back('{2'd0, 4'hA, MODE_BLINK});
        sb_q.push_back('{2'd1, 4'h5, MODE_DOT});
        sb_q.push_back('{2'd0, 4'hA, MODE_BLINK});
        sb_q.push_back('{2'd1, 4'h5, MODE_DOT});
        for (int i = 0; i < 60 && nacks < 4; i++) begin
            @(negedge i_clk);
            if (o_ack !== '0) begin
                ack_cyc[nacks] = cyc;
                nacks++;
            end
        end
        i_req = '0;
        checkOutput("cont_ack_count", 32'(nacks), 32'd4);
        for (int i = 0; i < 3; i++)
            checkOutput("cont_spacing", 32'(ack_cyc[i+1] - ack_cyc[i]), 32'(HOLD + GAP + 1));
        waitIdle("cont_idle");

        $display("[TB] flush");
        i_req   = 2'b01;
        i_value = 8'h5A;
        i_mode  = {3'd2, 3'd1};
        sb_q.push_back('{2'd0, 4'hA, 3'd1});
        @(negedge i_clk);
        i_req   = '0;
        i_value = 8'h53;
        @(negedge i_clk);
        checkOutput("flush_pre_num", 32'(o_binary_num), 32'hA);
        i_flush = 1'b1;
        @(negedge i_clk);
        checkOutput("flush_blank", 32'(o_blank), 32'h1);
        checkOutput("flush_busy", 32'(o_busy), 32'h0);
        checkOutput("flush_ack", 32'(o_ack), 32'h0);
        i_req   = 2'b01;
        @(negedge i_clk);
        checkOutput("flush_grant_ack", 32'(o_ack), 32'h0);
        checkOutput("flush_grant_busy", 32'(o_busy), 32'h0);
        checkOutput("flush_grant_blank", 32'(o_blank), 32'h1);
        i_flush = 1'b0;
        i_req   = 2'b11;
        i_value = 8'h5A;
        sb_q.push_back('{2'd1, 4'h5, 3'd2});
        @(negedge i_clk);
        checkOutput("flush_ptr_kept", 32'(o_ack), 32'b10);
        i_req = '0;
        waitIdle("flush_idle");

        $display("[TB] no-gap build");
        ng_req   = 2'b01;
        ng_value = 8'h07;
        ng_mode  = {3'd0, 3'd3};
        ng_show  = 0;
        k = 0;
        do begin
            @(negedge i_clk);
            k++;
        end while (ng_ack === '0 && k < 10);
        checkOutput("ng_first_ack", 32'(ng_ack), 32'b01);
        checkOutput("ng_num", 32'(ng_num), 32'h7);
        t0 = cyc;
        for (int i = 1; i < HOLD; i++) begin
            @(negedge i_clk);
            if (ng_blank === 1'b0 && ng_busy === 1'b1) ng_show++;
        end
        checkOutput("ng_show_cycles", 32'(ng_show), 32'(HOLD - 1));
        @(negedge i_clk);
        checkOutput("ng_no_gap_busy", 32'(ng_busy), 32'h0);
        checkOutput("ng_no_gap_blank", 32'(ng_blank), 32'h1);
        k = 0;
        do begin
            @(negedge i_clk);
            k++;
        end while (ng_ack === '0 && k < 10);
        checkOutput("ng_second_ack", 32'(ng_ack), 32'b01);
        checkOutput("ng_spacing", 32'(cyc - t0), 32'(HOLD + 1));
        ng_req = '0;
        waitIdle("ng_main_idle");

        $display("[TB] async reset mid-gap");
        i_req   = 2'b01;
        i_value = 8'h5A;
        i_mode  = {3'd2, 3'd1};
        sb_q.push_back('{2'd0, 4'hA, 3'd1});
        @(negedge i_clk);
        i_req = '0;
        repeat (HOLD) @(negedge i_clk);
        checkOutput("gap_blank", 32'(o_blank), 32'h1);
        checkOutput("gap_busy", 32'(o_busy), 32'h1);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("arst_blank", 32'(o_blank), 32'h1);
        checkOutput("arst_busy", 32'(o_busy), 32'h0);
        checkOutput("arst_ack", 32'(o_ack), 32'h0);
        checkOutput("arst_num", 32'(o_binary_num), 32'h0);
        checkOutput("arst_mode", 32'(o_mode), 32'h0);
        checkOutput("arst_owner", 32'(o_owner), 32'h0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_req   = 2'b11;
        sb_q.push_back('{2'd0, 4'hA, 3'd1});
        @(negedge i_clk);
        checkOutput("arst_ptr_cleared", 32'(o_ack), 32'b01);
        i_req = '0;
        waitIdle("arst_idle");

        checkOutput("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
